// File: rtl/mux_seq.sv
// Registered N-channel multiplexer with manual select and round-robin scan sequencer.
// Optional per-channel enable mask is compiled in with `define MUXSEQ_MASK_EN.
module mux_seq #(
  parameter  int N     = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 10,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   d,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             run,
`ifdef MUXSEQ_MASK_EN
  input  logic [N-1:0]     en_mask,
`endif
  output logic [W-1:0]     y,
  output logic [SEL_W-1:0] ch,
  output logic             strobe,
  output logic             wrap,
  output logic             busy
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     y_q, y_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     en;
  logic             any_en;

`ifdef MUXSEQ_MASK_EN
  assign en = en_mask;
`else
  assign en = '1;
`endif
  assign any_en = |en;

  // Data of channel idx, forced to zero when that channel is disabled.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] dv,
                                        input logic [N-1:0]   m,
                                        input logic [SEL_W-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(idx) == k && m[k]) r = dv[k*W +: W];
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] first_en(input logic [N-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (m[k]) r = SEL_W'(k);
    end
    return r;
  endfunction

  // Descending offset scan so the nearest enabled successor wins; a lone channel returns itself.
  function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] cur,
                                               input logic [N-1:0]     m);
    logic [SEL_W-1:0] r;
    r = cur;
    for (int i = N - 1; i >= 1; i--) begin
      if (m[(int'(cur) + i) % N]) r = SEL_W'((int'(cur) + i) % N);
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    ch_d     = ch_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;

    if (!run) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!mode) begin
      state_d = MANUAL;
      cnt_d   = '0;
      if (int'(sel) < N) ch_d = sel;
      y_d      = pick(d, en, ch_d);
      strobe_d = (ch_d != ch_q);
    end else if (state_q != SCAN) begin
      state_d = SCAN;
      cnt_d   = '0;
      if (any_en) begin
        ch_d     = first_en(en);
        strobe_d = 1'b1;
      end
      y_d = pick(d, en, ch_d);
    end else begin
      if (int'(cnt_q) == DWELL - 1) begin
        cnt_d = '0;
        if (any_en) begin
          ch_d     = next_en(ch_q, en);
          strobe_d = 1'b1;
          wrap_d   = (ch_d <= ch_q);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      y_d = pick(d, en, ch_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      y_q      <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign y      = y_q;
  assign ch     = ch_q;
  assign strobe = strobe_q;
  assign wrap   = wrap_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mux_seq.sv
// Directed bench for mux_seq: three instances (DWELL=3, DWELL=1, N=3) checked through a scoreboard.
// Mask scenarios run only when MUXSEQ_MASK_EN is defined.
module tb_mux_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic run_a, run_b, run_c;
  logic [1:0]  sel, sel_c;
  logic [31:0] d_a;
  logic [23:0] d_c;
  logic [7:0]  y_a, y_b, y_c;
  logic [1:0]  ch_a, ch_b, ch_c;
  logic        st_a, st_b, st_c, wr_a, wr_b, wr_c, bz_a, bz_b, bz_c;
`ifdef MUXSEQ_MASK_EN
  logic [3:0]  mask_a = 4'hF;
  logic [3:0]  mask_b = 4'hF;
  logic [2:0]  mask_c = 3'h7;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int         id;
    string      tag;
    logic [7:0] y;
    logic [1:0] ch;
    logic       s;
    logic       w;
    logic       b;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux_seq #(.N(4), .W(8), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .mode(mode), .sel(sel), .run(run_a),
`ifdef MUXSEQ_MASK_EN
    .en_mask(mask_a),
`endif
    .y(y_a), .ch(ch_a), .strobe(st_a), .wrap(wr_a), .busy(bz_a)
  );

  mux_seq #(.N(4), .W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_a), .mode(mode), .sel(sel), .run(run_b),
`ifdef MUXSEQ_MASK_EN
    .en_mask(mask_b),
`endif
    .y(y_b), .ch(ch_b), .strobe(st_b), .wrap(wr_b), .busy(bz_b)
  );

  mux_seq #(.N(3), .W(8), .DWELL(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .d(d_c), .mode(mode), .sel(sel_c), .run(run_c),
`ifdef MUXSEQ_MASK_EN
    .en_mask(mask_c),
`endif
    .y(y_c), .ch(ch_c), .strobe(st_c), .wrap(wr_c), .busy(bz_c)
  );

  // Reset contents of d_a: channel k carries 0x11*(k+1).
  function automatic logic [7:0] dat(input int k);
    return 8'((k + 1) * 17);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    case (e.id)
      0: begin
        chk({e.tag, ".y"}, y_a, e.y);   chk({e.tag, ".ch"}, 8'(ch_a), 8'(e.ch));
        chk({e.tag, ".strobe"}, 8'(st_a), 8'(e.s)); chk({e.tag, ".wrap"}, 8'(wr_a), 8'(e.w));
        chk({e.tag, ".busy"}, 8'(bz_a), 8'(e.b));
      end
      1: begin
        chk({e.tag, ".y"}, y_b, e.y);   chk({e.tag, ".ch"}, 8'(ch_b), 8'(e.ch));
        chk({e.tag, ".strobe"}, 8'(st_b), 8'(e.s)); chk({e.tag, ".wrap"}, 8'(wr_b), 8'(e.w));
        chk({e.tag, ".busy"}, 8'(bz_b), 8'(e.b));
      end
      default: begin
        chk({e.tag, ".y"}, y_c, e.y);   chk({e.tag, ".ch"}, 8'(ch_c), 8'(e.ch));
        chk({e.tag, ".strobe"}, 8'(st_c), 8'(e.s)); chk({e.tag, ".wrap"}, 8'(wr_c), 8'(e.w));
        chk({e.tag, ".busy"}, 8'(bz_c), 8'(e.b));
      end
    endcase
  endtask

  // Queue the expectation for the coming edge, clock once, then compare 1 time unit later.
  task automatic tick(input int id, input string tag, input logic [7:0] ey,
                      input logic [1:0] ech, input logic es, input logic ew, input logic eb);
    sb.push_back('{id, tag, ey, ech, es, ew, eb});
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // Combinational check with no clock edge involved (asynchronous reset).
  task automatic now(input int id, input string tag, input logic [7:0] ey,
                     input logic [1:0] ech, input logic es, input logic ew, input logic eb);
    sb.push_back('{id, tag, ey, ech, es, ew, eb});
    compare_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; sel_c = 2'd0;
    run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
    d_a = {8'h44, 8'h33, 8'h22, 8'h11};
    d_c = {8'hC3, 8'hB2, 8'hA1};
    #2;
    now(0, "reset_a", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    now(2, "reset_c", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(0, "idle", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // Manual sweep: strobe only on the first cycle a new channel is taken.
    run_a = 1'b1; mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      for (int i = 0; i < 3; i++)
        tick(0, $sformatf("man%0d_%0d", s, i), dat(s), 2'(s), (i == 0 && s != 0), 1'b0, 1'b1);
    end
    d_a[31:24] = 8'h5A;
    tick(0, "man_live", 8'h5A, 2'd3, 1'b0, 1'b0, 1'b1);
    d_a[31:24] = 8'h44;

    // MANUAL->SCAN restarts at channel 0; k counts cycles since entry.
    mode = 1'b1;
    for (int k = 0; k <= 31; k++)
      tick(0, $sformatf("scan_k%0d", k), dat((k / 3) % 4), 2'((k / 3) % 4),
           (k % 3 == 0), (k > 0 && k % 12 == 0), 1'b1);

    // Hold at ch=2: outputs freeze even if the selected input changes.
    run_a = 1'b0;
    tick(0, "hold0", 8'h33, 2'd2, 1'b0, 1'b0, 1'b0);
    d_a[23:16] = 8'hEE;
    tick(0, "hold1", 8'h33, 2'd2, 1'b0, 1'b0, 1'b0);
    tick(0, "hold2", 8'h33, 2'd2, 1'b0, 1'b0, 1'b0);
    d_a[23:16] = 8'h33;

    run_a = 1'b1;
    tick(0, "restart", 8'h11, 2'd0, 1'b1, 1'b0, 1'b1);
    d_a[7:0] = 8'h99;
    tick(0, "scan_live", 8'h99, 2'd0, 1'b0, 1'b0, 1'b1);
    d_a[7:0] = 8'h11;
    tick(0, "rs_k2", 8'h11, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(0, "rs_k3", 8'h22, 2'd1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges while strobe is high.
    #2;
    rst_n = 1'b0;
    #1;
    now(0, "async_rst", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    run_a = 1'b0;
    #3;
    rst_n = 1'b1;

    // N=3: sel=3 is out of range, channel holds and y follows the held channel.
    run_c = 1'b1; mode = 1'b0; sel_c = 2'd2;
    tick(2, "c_sel2", 8'hC3, 2'd2, 1'b1, 1'b0, 1'b1);
    sel_c = 2'd3;
    tick(2, "c_sel3", 8'hC3, 2'd2, 1'b0, 1'b0, 1'b1);
    d_c[23:16] = 8'h3C;
    tick(2, "c_sel3_live", 8'h3C, 2'd2, 1'b0, 1'b0, 1'b1);
    sel_c = 2'd1;
    tick(2, "c_sel1", 8'hB2, 2'd1, 1'b1, 1'b0, 1'b1);
    run_c = 1'b0;
    tick(2, "c_idle", 8'hB2, 2'd1, 1'b0, 1'b0, 1'b0);

    // DWELL=1: advance every cycle, strobe stays high, wrap every N cycles.
    run_b = 1'b1; mode = 1'b1;
    for (int k = 0; k <= 10; k++)
      tick(1, $sformatf("d1_k%0d", k), dat(k % 4), 2'(k % 4), 1'b1, (k > 0 && k % 4 == 0), 1'b1);
    mode = 1'b0; sel = 2'd1;
    tick(1, "d1_to_man", dat(1), 2'd1, 1'b1, 1'b0, 1'b1);
    tick(1, "d1_man_hold", dat(1), 2'd1, 1'b0, 1'b0, 1'b1);
    run_b = 1'b0;
    tick(1, "d1_idle", dat(1), 2'd1, 1'b0, 1'b0, 1'b0);

`ifdef MUXSEQ_MASK_EN
    // Only channels 1 and 3 enabled; wrap on each 3->1 step.
    mask_a = 4'b1010; run_a = 1'b1; mode = 1'b1;
    for (int k = 0; k <= 12; k++)
      tick(0, $sformatf("mask_k%0d", k), ((k / 3) % 2 == 1) ? dat(3) : dat(1),
           ((k / 3) % 2 == 1) ? 2'd3 : 2'd1, (k % 3 == 0),
           (k > 0 && k % 3 == 0 && (k / 3) % 2 == 0), 1'b1);
    mask_a = 4'b0000;
    for (int k = 0; k < 4; k++)
      tick(0, $sformatf("mask0_%0d", k), 8'h00, 2'd1, 1'b0, 1'b0, 1'b1);
    mask_a = 4'b1101; mode = 1'b0; sel = 2'd1;
    tick(0, "mask_man", 8'h00, 2'd1, 1'b0, 1'b0, 1'b1);
    run_a = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
